// File: rtl/iter_muldiv_if.sv
// Request/result bundle between the register-file read stage and the iterative
// multiply/divide unit; the master issues operations, the slave returns one write-back beat.
interface iter_muldiv_if #(
  parameter int W = 64
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   dst;
  logic         busy;
  logic         done;
  logic [W-1:0] wd;
  logic [4:0]   wa;
  logic         we;

  modport master (
    output start, op, a, b, dst,
    input  busy, done, wd, wa, we
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, done, wd, wa, we
  );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative 64-bit MUL/UMULH/UDIV/SDIV unit, one bit per clock, producing a single
// register-file write-back beat (wd/wa/we) when the operation completes.
module iter_muldiv #(
  parameter int W     = 64,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  iter_muldiv_if.slave bus
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;
  localparam logic [4:0] XZR      = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       dst_q, dst_d;
  logic             sq_q, sq_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     wd_q, wd_d;
  logic [4:0]       wa_q, wa_d;

  logic             busy_s, done_s, we_s;

  // Accept-time operand conditioning
  logic             in_is_div;
  logic             in_div0;
  logic             in_sdiv;
  logic [W-1:0]     abs_a, abs_b;

  assign in_is_div = bus.op[1];
  assign in_sdiv   = (bus.op == OP_SDIV);
  assign in_div0   = in_is_div && (bus.b == '0);
  assign abs_a     = (in_sdiv && bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
  assign abs_b     = (in_sdiv && bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;

  // Multiply step: acc = {partial_hi, multiplier}; add multiplicand when the LSB is set, shift right.
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_step;
  // Divide step: acc = {remainder, dividend/quotient}; restoring trial subtract on the shifted remainder.
  logic [W:0]       div_trial;
  logic             div_ok;
  logic [2*W-1:0]   div_step;
  logic [2*W-1:0]   step_val;
  logic [W-1:0]     quot;
  logic [W-1:0]     result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_step  = {mul_sum, acc_q[W-1:1]};
    div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    div_ok    = ~div_trial[W];
    div_step  = div_ok ? {div_trial[W-1:0], acc_q[W-2:0], 1'b1}
                       : {acc_q[2*W-2:0], 1'b0};
    step_val  = op_q[1] ? div_step : mul_step;
    quot      = step_val[W-1:0];
    result    = step_val[W-1:0];
    case (op_q)
      OP_MUL:   result = step_val[W-1:0];
      OP_UMULH: result = step_val[2*W-1:W];
      OP_UDIV:  result = quot;
      OP_SDIV:  result = sq_q ? (~quot + 1'b1) : quot;
      default:  result = step_val[W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      dst_q   <= '0;
      sq_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      wd_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      sq_q    <= sq_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dst_d   = dst_q;
    sq_d    = sq_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    wd_d    = wd_q;
    wa_d    = wa_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          dst_d = bus.dst;
          cnt_d = CNT_W'(W - 1);
          sq_d  = in_sdiv && (bus.a[W-1] ^ bus.b[W-1]);
          if (in_div0) begin
            state_d = S_DONE;
            wd_d    = '0;
            wa_d    = bus.dst;
          end else begin
            state_d = S_RUN;
            if (in_is_div) begin
              acc_d  = {{W{1'b0}}, abs_a};
              opnd_d = abs_b;
            end else begin
              acc_d  = {{W{1'b0}}, bus.b};
              opnd_d = bus.a;
            end
          end
        end
      end
      S_RUN: begin
        acc_d = step_val;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          wd_d    = result;
          wa_d    = dst_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_s = (state_q != S_IDLE);
    done_s = (state_q == S_DONE);
    we_s   = done_s && (wa_q != XZR);
  end

  assign bus.busy = busy_s;
  assign bus.done = done_s;
  assign bus.we   = we_s;
  assign bus.wd   = wd_q;
  assign bus.wa   = wa_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: directed vector table, random ops against an
// arithmetic reference, and hand sequences for held start, mid-run changes and mid-run reset.
module tb_iter_muldiv;
  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iter_muldiv_if #(.W(W)) bus ();

  iter_muldiv #(.W(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0] dst;
    logic [W-1:0] exp_wd;
    logic       exp_we;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0]      p;
    logic signed [W-1:0] sa, sb;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sa = a;
    sb = b;
    case (op)
      2'd0: return p[W-1:0];
      2'd1: return p[2*W-1:W];
      2'd2: return (b == '0) ? '0 : a / b;
      default: begin
        if (b == '0) return '0;
        if (a == MINV && b == ONES) return MINV;
        return sa / sb;
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] dst, output logic [W-1:0] wd, output logic [4:0] wa,
                        output logic we, output int lat, output int busy_cyc);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dst   = dst;
    step();
    bus.start = 1'b0;
    lat       = 1;
    busy_cyc  = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      step();
      lat++;
      if (bus.busy === 1'b1) busy_cyc++;
    end
    wd = bus.wd;
    wa = bus.wa;
    we = bus.we;
  endtask

  initial begin
    logic [W-1:0] wd, ra, rb, exp;
    logic [4:0]   wa, rdst;
    logic         we;
    logic [1:0]   rop;
    int           lat, bc, n, done_cnt;
    int           done_t[$];

    vecs[0]  = '{"mul_7x6",      2'd0, 64'd7, 64'd6, 5'd3, 64'd42, 1'b1, W+1};
    vecs[1]  = '{"umulh_ones",   2'd1, ONES, ONES, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, W+1};
    vecs[2]  = '{"mul_ones",     2'd0, ONES, ONES, 5'd6, 64'd1, 1'b1, W+1};
    vecs[3]  = '{"sdiv_m7_2",    2'd3, -64'sd7, 64'd2, 5'd7, -64'sd3, 1'b1, W+1};
    vecs[4]  = '{"udiv_100_7",   2'd2, 64'd100, 64'd7, 5'd8, 64'd14, 1'b1, W+1};
    vecs[5]  = '{"sdiv_min_m1",  2'd3, MINV, ONES, 5'd9, MINV, 1'b1, W+1};
    vecs[6]  = '{"udiv_by0",     2'd2, 64'd5, 64'd0, 5'd10, 64'd0, 1'b1, 1};
    vecs[7]  = '{"udiv_by0_xzr", 2'd2, 64'd5, 64'd0, 5'd31, 64'd0, 1'b0, 1};
    vecs[8]  = '{"sdiv_7_m2",    2'd3, 64'd7, -64'sd2, 5'd1, -64'sd3, 1'b1, W+1};
    vecs[9]  = '{"mul_xzr",      2'd0, -64'sd3, 64'd5, 5'd31, -64'sd15, 1'b0, W+1};
    vecs[10] = '{"sdiv_by0",     2'd3, -64'sd5, 64'd0, 5'd2, 64'd0, 1'b1, 1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.dst   = '0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_we",   W'(bus.we),   '0);
    check("rst_wd",   bus.wd,       '0);
    check("rst_wa",   W'(bus.wa),   '0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, wd, wa, we, lat, bc);
      $display("vec %s op=%0d a=0x%0h b=0x%0h dst=%0d -> wd=0x%0h wa=%0d we=%0d lat=%0d",
               vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, wd, wa, we, lat);
      check({vecs[i].name, "_wd"},   wd, vecs[i].exp_wd);
      check({vecs[i].name, "_wa"},   W'(wa), W'(vecs[i].dst));
      check({vecs[i].name, "_we"},   W'(we), W'(vecs[i].exp_we));
      check({vecs[i].name, "_lat"},  W'(lat), W'(vecs[i].exp_lat));
      check({vecs[i].name, "_busy"}, W'(bc), W'(vecs[i].exp_lat));
      step();
      check({vecs[i].name, "_done1"}, W'(bus.done), '0);
      check({vecs[i].name, "_idle"},  W'(bus.busy), '0);
      check({vecs[i].name, "_hold"},  bus.wd, vecs[i].exp_wd);
    end

    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      rb   = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) rb = '0;
      rdst = 5'($urandom_range(0, 31));
      exp  = model(rop, ra, rb);
      run_op(rop, ra, rb, rdst, wd, wa, we, lat, bc);
      $display("rnd %0d op=%0d a=0x%0h b=0x%0h dst=%0d -> wd=0x%0h exp=0x%0h lat=%0d",
               i, rop, ra, rb, rdst, wd, exp, lat);
      check("rnd_wd",  wd, exp);
      check("rnd_wa",  W'(wa), W'(rdst));
      check("rnd_we",  W'(we), W'(rdst != 5'd31));
      check("rnd_lat", W'(lat), W'((rop[1] && rb == '0) ? 1 : W + 1));
      step();
    end

    // Start held high: accepts must be spaced W+2 cycles apart.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 64'd2;
    bus.b     = 64'd3;
    bus.dst   = 5'd4;
    for (int t = 1; t <= 3 * (W + 2) + 2; t++) begin
      step();
      if (bus.done === 1'b1) done_t.push_back(t);
    end
    bus.start = 1'b0;
    $display("held start: %0d done pulses", done_t.size());
    check("held_count", W'(done_t.size()), W'(3));
    if (done_t.size() == 3) begin
      check("held_gap1", W'(done_t[1] - done_t[0]), W'(W + 2));
      check("held_gap2", W'(done_t[2] - done_t[1]), W'(W + 2));
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check("held_drain", W'(bus.busy), '0);

    // Operands and op changed mid-RUN must not affect the result.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 64'd7;
    bus.b     = 64'd6;
    bus.dst   = 5'd3;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    bus.op  = 2'd2;
    bus.a   = 64'd99;
    bus.b   = 64'd98;
    bus.dst = 5'd20;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    $display("midrun change: wd=0x%0h wa=%0d", bus.wd, bus.wa);
    check("midrun_wd", bus.wd, 64'd42);
    check("midrun_wa", W'(bus.wa), W'(3));
    step();

    // Reset at RUN cycle 30 aborts without a write-back.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 64'd12345;
    bus.b     = 64'd678;
    bus.dst   = 5'd4;
    step();
    bus.start = 1'b0;
    repeat (29) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("midrun reset: busy=%0d done=%0d we=%0d wd=0x%0h", bus.busy, bus.done, bus.we, bus.wd);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    check("abort_we",   W'(bus.we),   '0);
    check("abort_wd",   bus.wd,       '0);
    done_cnt = 0;
    repeat (W + 10) begin
      step();
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", W'(done_cnt), '0);
    run_op(2'd0, 64'd3, 64'd3, 5'd12, wd, wa, we, lat, bc);
    $display("post-reset mul 3*3 -> wd=0x%0h lat=%0d", wd, lat);
    check("post_rst_wd",  wd, 64'd9);
    check("post_rst_lat", W'(lat), W'(W + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
